mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/arb_sat_counter.sv | 24 ++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_DM = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  // Consecutive instruction-fetch losses before fetch is forced to win.
  localparam int DEF_MAX_WAIT = 3;
  // Grant cycles allowed without mem_rdy before the access is aborted.
  localparam int DEF_TIMEOUT  = 15;

endpackage

// File: rtl/arb_sat_counter.sv
// Clearable up-counter that holds once it reaches LIMIT.
module arb_sat_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  // Clear wins over increment; increment stops at LIMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != WIDTH'(LIMIT))) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (IF) and
// data memory (DM). DM normally wins; IF is forced through after MAX_WAIT
// consecutive losses. Stuck accesses are aborted after TIMEOUT grant cycles.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdy,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_t  state_reg, state_next;
  logic [31:0] addr_reg, wdata_reg, rdata_reg;
  logic        we_reg, resp_dm_reg, err_reg;
  logic [WW-1:0] wait_cnt;
  logic [TW-1:0] tmo_cnt;
  logic        grant_if, grant_dm, wait_inc, wait_clr;
  logic        done_ok, done_abort, in_gnt, in_resp;

  assign in_gnt  = (state_reg == GNT_IF) || (state_reg == GNT_DM);
  assign in_resp = (state_reg == RESP);

  // Counts consecutive IF losses; cleared when IF finally gets the port.
  arb_sat_counter #(.WIDTH(WW), .LIMIT(MAX_WAIT)) u_wait_cnt (
    .clk (CLK),
    .rst (RST),
    .clr (wait_clr),
    .inc (wait_inc),
    .cnt (wait_cnt)
  );

  // Counts grant cycles; zero at the first cycle of every grant.
  arb_sat_counter #(.WIDTH(TW), .LIMIT(TIMEOUT)) u_tmo_cnt (
    .clk (CLK),
    .rst (RST),
    .clr (!in_gnt),
    .inc (in_gnt),
    .cnt (tmo_cnt)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Arbitration decision and grant completion / timeout detection.
  always_comb begin
    state_next = state_reg;
    grant_if   = 1'b0;
    grant_dm   = 1'b0;
    wait_inc   = 1'b0;
    wait_clr   = 1'b0;
    done_ok    = 1'b0;
    done_abort = 1'b0;
    case (state_reg)
      IDLE: begin
        if (if_req && dm_req) begin
          if (wait_cnt == WW'(MAX_WAIT)) begin
            grant_if = 1'b1;
          end else begin
            grant_dm = 1'b1;
            wait_inc = 1'b1;
          end
        end else if (if_req) begin
          grant_if = 1'b1;
        end else if (dm_req) begin
          grant_dm = 1'b1;
        end
        if (grant_if) begin
          state_next = GNT_IF;
          wait_clr   = 1'b1;
        end else if (grant_dm) begin
          state_next = GNT_DM;
        end
      end
      GNT_IF, GNT_DM: begin
        // A completion on the final allowed cycle still counts as success.
        if (mem_rdy) begin
          done_ok    = 1'b1;
          state_next = RESP;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          done_abort = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the winning request at grant time and the result at completion.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_reg    <= '0;
      wdata_reg   <= '0;
      we_reg      <= 1'b0;
      resp_dm_reg <= 1'b0;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
    end else begin
      if (grant_if) begin
        addr_reg    <= if_addr;
        wdata_reg   <= '0;
        we_reg      <= 1'b0;
        resp_dm_reg <= 1'b0;
      end else if (grant_dm) begin
        addr_reg    <= dm_addr;
        wdata_reg   <= dm_wdata;
        we_reg      <= dm_we;
        resp_dm_reg <= 1'b1;
      end
      if (done_ok) begin
        rdata_reg <= we_reg ? 32'h0 : mem_rdata;
        err_reg   <= 1'b0;
      end else if (done_abort) begin
        rdata_reg <= '0;
        err_reg   <= 1'b1;
      end
    end
  end

  assign mem_cs    = in_gnt;
  assign mem_we    = in_gnt & we_reg;
  assign mem_addr  = in_gnt ? addr_reg : 32'h0;
  assign mem_wdata = in_gnt ? wdata_reg : 32'h0;

  assign if_ack    = in_resp & ~resp_dm_reg;
  assign dm_ack    = in_resp & resp_dm_reg;
  assign if_rdata  = if_ack ? rdata_reg : 32'h0;
  assign dm_rdata  = dm_ack ? rdata_reg : 32'h0;
  assign err       = in_resp & err_reg;

  // Stalls are forced low while reset is asserted so every output reads 0.
  assign stall_if  = ~RST & if_req & ~if_ack;
  assign stall_mem = ~RST & dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        CLK, RST;
  logic        if_req, dm_req, dm_we, mem_rdy;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ack, dm_ack, mem_cs, mem_we, stall_if, stall_mem, err;

  int pass_cnt = 0;
  int total_cnt = 0;

  mem_port_arbiter #(.MAX_WAIT(3), .TIMEOUT(15)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ack    (dm_ack),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_rdy   (mem_rdy),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .err       (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [31:0] grant_exp [5];
    RST = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_rdy = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    step(); step();

    // Reset: every output 0, even with requests pending.
    if_req = 1'b1; dm_req = 1'b1; #1;
    chk("rst_mem_cs", {31'h0, mem_cs}, 32'h0);
    chk("rst_acks", {30'h0, if_ack, dm_ack}, 32'h0);
    chk("rst_stalls", {30'h0, stall_if, stall_mem}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'h0);

    // IF-only fetch, mem_rdy already high: ack in cycle 3.
    dm_req = 1'b0; if_addr = 32'h10; mem_rdy = 1'b1; mem_rdata = 32'hCAFE0001;
    step(); RST = 1'b0; #1;
    chk("if_c1_stall", {31'h0, stall_if}, 32'h1);
    chk("if_c1_cs", {31'h0, mem_cs}, 32'h0);
    step();
    chk("if_c2_cs", {31'h0, mem_cs}, 32'h1);
    chk("if_c2_addr", mem_addr, 32'h10);
    chk("if_c2_we", {31'h0, mem_we}, 32'h0);
    chk("if_c2_stall", {31'h0, stall_if}, 32'h1);
    chk("if_c2_ack", {31'h0, if_ack}, 32'h0);
    step();
    chk("if_c3_ack", {31'h0, if_ack}, 32'h1);
    chk("if_c3_rdata", if_rdata, 32'hCAFE0001);
    chk("if_c3_stall", {31'h0, stall_if}, 32'h0);
    chk("if_c3_dm_ack", {31'h0, dm_ack}, 32'h0);
    chk("if_c3_err", {31'h0, err}, 32'h0);
    if_req = 1'b0;
    step();
    chk("if_idle_ack", {31'h0, if_ack}, 32'h0);
    chk("if_idle_cs", {31'h0, mem_cs}, 32'h0);

    // Both held: DM,DM,DM,IF then DM again (wait count restarted).
    grant_exp[0] = 32'h200; grant_exp[1] = 32'h200; grant_exp[2] = 32'h200;
    grant_exp[3] = 32'h100; grant_exp[4] = 32'h200;
    if_addr = 32'h100; dm_addr = 32'h200; dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1; mem_rdy = 1'b1;
    for (int g = 0; g < 5; g++) begin
      mem_rdata = 32'hB000_0000 + 32'(g);
      step();
      chk($sformatf("arb%0d_grant_addr", g), mem_addr, grant_exp[g]);
      step();
      chk($sformatf("arb%0d_if_ack", g), {31'h0, if_ack}, (grant_exp[g] == 32'h100) ? 32'h1 : 32'h0);
      chk($sformatf("arb%0d_dm_ack", g), {31'h0, dm_ack}, (grant_exp[g] == 32'h200) ? 32'h1 : 32'h0);
      chk($sformatf("arb%0d_rdata", g), if_rdata | dm_rdata, 32'hB000_0000 + 32'(g));
      if (g == 4) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
      step();
      chk($sformatf("arb%0d_idle_cs", g), {31'h0, mem_cs}, 32'h0);
    end

    // DM write, mem_rdy on the 4th grant cycle; later input changes ignored.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
    mem_rdy = 1'b0; mem_rdata = 32'h12345678;
    step();
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("wr_c%0d_we", k), {31'h0, mem_we}, 32'h1);
      chk($sformatf("wr_c%0d_addr", k), mem_addr, 32'h40);
      chk($sformatf("wr_c%0d_wdata", k), mem_wdata, 32'hDEADBEEF);
      chk($sformatf("wr_c%0d_stall", k), {31'h0, stall_mem}, 32'h1);
      if (k == 2) begin
        dm_addr = 32'h44; dm_wdata = 32'h0; dm_we = 1'b0;
      end
      if (k == 4) mem_rdy = 1'b1;
      step();
    end
    chk("wr_ack", {31'h0, dm_ack}, 32'h1);
    chk("wr_rdata", dm_rdata, 32'h0);
    chk("wr_err", {31'h0, err}, 32'h0);
    chk("wr_resp_we", {31'h0, mem_we}, 32'h0);
    dm_req = 1'b0; mem_rdy = 1'b0;
    step();

    // IF access that never completes: abort after 15 grant cycles.
    if_req = 1'b1; if_addr = 32'h80; mem_rdata = 32'h55AA55AA;
    step();
    for (int k = 1; k <= 15; k++) begin
      chk($sformatf("tmo_c%0d_cs", k), {31'h0, mem_cs}, 32'h1);
      chk($sformatf("tmo_c%0d_ack", k), {31'h0, if_ack}, 32'h0);
      step();
    end
    chk("tmo_ack", {31'h0, if_ack}, 32'h1);
    chk("tmo_err", {31'h0, err}, 32'h1);
    chk("tmo_rdata", if_rdata, 32'h0);
    chk("tmo_resp_cs", {31'h0, mem_cs}, 32'h0);
    if_req = 1'b0;
    step();
    chk("tmo_err_pulse", {31'h0, err}, 32'h0);

    // DM read completing on the last allowed cycle counts as success.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h90; mem_rdata = 32'hA5A5A5A5;
    step();
    for (int k = 1; k <= 15; k++) begin
      if (k == 15) mem_rdy = 1'b1;
      step();
    end
    chk("edge_ack", {31'h0, dm_ack}, 32'h1);
    chk("edge_err", {31'h0, err}, 32'h0);
    chk("edge_rdata", dm_rdata, 32'hA5A5A5A5);
    dm_req = 1'b0; mem_rdy = 1'b0;
    step();

    // Reset in the 2nd GNT_DM cycle: immediate abort, then re-grant.
    dm_req = 1'b1; dm_addr = 32'h60; mem_rdata = 32'h0BADF00D;
    step();
    step();
    chk("rg_c2_cs", {31'h0, mem_cs}, 32'h1);
    #2 RST = 1'b1; #1;
    chk("rg_async_cs", {31'h0, mem_cs}, 32'h0);
    chk("rg_async_ack", {31'h0, dm_ack}, 32'h0);
    step();
    chk("rg_hold_ack", {31'h0, dm_ack}, 32'h0);
    RST = 1'b0;
    step();
    chk("rg_regrant_cs", {31'h0, mem_cs}, 32'h1);
    chk("rg_regrant_addr", mem_addr, 32'h60);
    mem_rdy = 1'b1;
    step();
    chk("rg_ack", {31'h0, dm_ack}, 32'h1);
    chk("rg_rdata", dm_rdata, 32'h0BADF00D);
    dm_req = 1'b0; mem_rdy = 1'b0;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
